// File: rtl/pwm_duty_sequencer.sv
// PWM duty sequencer: ramps the comparator duty toward a target
// set by the host or by inc/dec pulses, one step per PWM period.
module pwm_duty_sequencer #(
    parameter int DUTY_MAX  = 10,
    parameter int INIT_DUTY = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       period_start,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    input  logic       host_valid,
    input  logic [3:0] host_duty,
    output logic       host_ready,
    input  logic [7:0] ramp_div,
    output logic [3:0] duty_out,
    output logic       busy,
    output logic       err_range
);

    localparam logic [3:0] DMAX = 4'(DUTY_MAX);
    localparam logic [3:0] INIT = 4'(INIT_DUTY);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] target;
    logic [3:0] target_nxt;
    logic [3:0] duty_nxt;
    logic [7:0] div_cnt;
    logic [7:0] div_nxt;
    logic       err_nxt;
    logic       accept;

    assign host_ready = (state == IDLE);
    assign busy       = (state == RAMP);
    assign accept     = host_valid && host_ready;

    // Next target, ramp step and state; ramp compares the pre-update target.
    always_comb begin
        target_nxt = target;
        duty_nxt   = duty_out;
        div_nxt    = div_cnt;
        err_nxt    = 1'b0;
        state_nxt  = state;

        if (accept) begin
            err_nxt    = (host_duty > DMAX);
            target_nxt = (host_duty > DMAX) ? DMAX : host_duty;
        end else begin
            unique case (1'b1)
                (inc_pulse && !dec_pulse):
                    target_nxt = (target >= DMAX) ? DMAX : 4'(target + 4'd1);
                (dec_pulse && !inc_pulse):
                    target_nxt = (target == 4'd0) ? 4'd0 : 4'(target - 4'd1);
                default:
                    target_nxt = target;
            endcase
        end

        if (state == RAMP && period_start) begin
            if (div_cnt >= ramp_div) begin
                div_nxt = 8'd0;
                if (duty_out < target) begin
                    duty_nxt = 4'(duty_out + 4'd1);
                end else if (duty_out > target) begin
                    duty_nxt = 4'(duty_out - 4'd1);
                end
            end else begin
                div_nxt = 8'(div_cnt + 8'd1);
            end
        end

        state_nxt = (duty_nxt != target_nxt) ? RAMP : IDLE;
        if (state_nxt == IDLE) begin
            div_nxt = 8'd0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= INIT;
            duty_out  <= INIT;
            div_cnt   <= 8'd0;
            err_range <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            duty_out  <= duty_nxt;
            div_cnt   <= div_nxt;
            err_range <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: stimulus queues expected
// outputs, monitors compare timed snapshots and every duty_out change.
module tb_pwm_duty_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       period_start;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       host_valid;
    logic [3:0] host_duty;
    logic       host_ready;
    logic [7:0] ramp_div;
    logic [3:0] duty_out;
    logic       busy;
    logic       err_range;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit armed = 0;
    bit done  = 0;
    logic [3:0] prev_duty;

    typedef struct {
        int         cyc;
        logic [3:0] duty;
        logic       busy;
        logic       ready;
        logic       err;
        string      name;
    } exp_t;

    exp_t       snap_q[$];
    logic [3:0] duty_q[$];

    pwm_duty_sequencer #(.DUTY_MAX(10), .INIT_DUTY(5)) dut (
        .clk(clk),
        .rst(rst),
        .period_start(period_start),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .host_valid(host_valid),
        .host_duty(host_duty),
        .host_ready(host_ready),
        .ramp_div(ramp_div),
        .duty_out(duty_out),
        .busy(busy),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Timed snapshot monitor.
    always @(negedge clk) begin
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            exp_t e;
            e = snap_q.pop_front();
            tests++;
            if (e.cyc < cyc) begin
                fails++;
                $display("FAIL %s: check missed (cycle %0d, now %0d)",
                         e.name, e.cyc, cyc);
            end else if (duty_out !== e.duty || busy !== e.busy ||
                         host_ready !== e.ready || err_range !== e.err) begin
                fails++;
                $display("FAIL %s: got duty=%0d busy=%0b ready=%0b err=%0b, want duty=%0d busy=%0b ready=%0b err=%0b",
                         e.name, duty_out, busy, host_ready, err_range,
                         e.duty, e.busy, e.ready, e.err);
            end
        end
    end

    // Duty-change monitor: each change must match the next queued value.
    always @(negedge clk) begin
        if (armed && duty_out !== prev_duty) begin
            tests++;
            if (duty_q.size() == 0) begin
                fails++;
                $display("FAIL duty_change: got %0d, want no change from %0d",
                         duty_out, prev_duty);
            end else begin
                logic [3:0] w;
                w = duty_q.pop_front();
                if (duty_out !== w) begin
                    fails++;
                    $display("FAIL duty_change: got %0d, want %0d", duty_out, w);
                end
            end
        end
        prev_duty = duty_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input logic [3:0] d, input logic b,
                              input logic r, input logic e, input string n);
        exp_t x;
        x.cyc   = cyc;
        x.duty  = d;
        x.busy  = b;
        x.ready = r;
        x.err   = e;
        x.name  = n;
        snap_q.push_back(x);
    endtask

    task automatic host(input logic [3:0] d);
        host_valid = 1'b1;
        host_duty  = d;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic period(input int gap);
        repeat (gap) tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        period_start = 1'b0;
        inc_pulse    = 1'b0;
        dec_pulse    = 1'b0;
        host_valid   = 1'b1;
        host_duty    = 4'd9;
        ramp_div     = 8'd0;

        // Reset with a host transfer presented: transfer is lost.
        tick();
        tick();
        expect_now(4'd5, 1'b0, 1'b1, 1'b0, "reset_state");
        rst        = 1'b0;
        host_valid = 1'b0;
        tick();
        expect_now(4'd5, 1'b0, 1'b1, 1'b0, "reset_idle");
        prev_duty = 4'd5;
        armed     = 1;

        // Host ramp up to 8, step every period.
        host(4'd8);
        expect_now(4'd5, 1'b1, 1'b0, 1'b0, "accept_8");
        for (int i = 0; i < 3; i++) begin
            duty_q.push_back(4'(6 + i));
            period(9);
            expect_now(4'(6 + i), (i < 2), (i == 2), 1'b0, "ramp_up");
        end

        // Back down to 5.
        host(4'd5);
        for (int i = 0; i < 3; i++) begin
            duty_q.push_back(4'(7 - i));
            period(3);
        end
        expect_now(4'd5, 1'b0, 1'b1, 1'b0, "at_5");

        // Divided ramp: moves on 3rd and 6th period only.
        ramp_div = 8'd2;
        host(4'd3);
        duty_q.push_back(4'd4);
        duty_q.push_back(4'd3);
        for (int k = 1; k <= 6; k++) begin
            period(4);
            expect_now((k < 3) ? 4'd5 : ((k < 6) ? 4'd4 : 4'd3),
                       (k < 6), (k == 6), 1'b0, "div_ramp");
        end

        // Up to 10.
        ramp_div = 8'd0;
        host(4'd10);
        for (int i = 0; i < 7; i++) begin
            duty_q.push_back(4'(4 + i));
            period(2);
        end
        expect_now(4'd10, 1'b0, 1'b1, 1'b0, "at_10");

        // Saturation and conflicts.
        inc_pulse = 1'b1;
        tick();
        inc_pulse = 1'b0;
        expect_now(4'd10, 1'b0, 1'b1, 1'b0, "inc_sat");
        inc_pulse = 1'b1;
        dec_pulse = 1'b1;
        tick();
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        expect_now(4'd10, 1'b0, 1'b1, 1'b0, "inc_dec_both");
        dec_pulse = 1'b1;
        tick();
        dec_pulse = 1'b0;
        expect_now(4'd10, 1'b1, 1'b0, 1'b0, "dec_target_9");
        inc_pulse = 1'b1;
        tick();
        inc_pulse = 1'b0;
        expect_now(4'd10, 1'b0, 1'b1, 1'b0, "inc_back_10");

        // Host wins over a same-cycle dec.
        dec_pulse = 1'b1;
        host(4'd7);
        dec_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            duty_q.push_back(4'(9 - i));
            period(2);
        end
        expect_now(4'd7, 1'b0, 1'b1, 1'b0, "host_prio");

        // Out-of-range host value clamps to 10 and flags once.
        host(4'd13);
        expect_now(4'd7, 1'b1, 1'b0, 1'b1, "err_pulse");
        tick();
        expect_now(4'd7, 1'b1, 1'b0, 1'b0, "err_clear");
        for (int i = 0; i < 3; i++) begin
            duty_q.push_back(4'(8 + i));
            period(2);
        end
        expect_now(4'd10, 1'b0, 1'b1, 1'b0, "clamp_10");

        // Ramp toward 0, stop at 3 with div_cnt mid-count, then reset.
        host(4'd0);
        for (int i = 0; i < 7; i++) begin
            duty_q.push_back(4'(9 - i));
            period(2);
        end
        ramp_div = 8'd3;
        period(2);
        expect_now(4'd3, 1'b1, 1'b0, 1'b0, "pre_reset");
        duty_q.push_back(4'd5);
        rst          = 1'b1;
        host_valid   = 1'b1;
        host_duty    = 4'd2;
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        expect_now(4'd5, 1'b0, 1'b1, 1'b0, "mid_ramp_reset");
        rst        = 1'b0;
        host_valid = 1'b0;
        tick();
        expect_now(4'd5, 1'b0, 1'b1, 1'b0, "host_lost");

        // div_cnt cleared by reset: with ramp_div=1 the 1st period holds.
        ramp_div = 8'd1;
        host(4'd4);
        period(2);
        expect_now(4'd5, 1'b1, 1'b0, 1'b0, "div_cleared");
        duty_q.push_back(4'd4);
        period(2);
        expect_now(4'd4, 1'b0, 1'b1, 1'b0, "div_step");

        repeat (4) tick();
        tests++;
        if (snap_q.size() != 0 || duty_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     snap_q.size(), duty_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
